cruise_controller: RTL

- Cruise-control sequencer placed between the accelerator ADC path and the vehicle physics block.
- When engaged, it regulates the accelerator command that feeds the physics block so that vehicle speed tracks a stored set speed.
- The driver can always override, and the controller disengages on brake, cancel, gear change or engine off.
- The block outputs the effective accelerator value (driver or cruise) that the physics block consumes.

---
 rtl/cruise_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cruise_controller.sv
// Cruise-control sequencer: arbitrates driver vs. cruise accelerator and regulates
// the cruise command so vehicle speed tracks a stored set speed.
module cruise_controller #(
   parameter int MIN_SPEED = 30,
   parameter int MAX_SPEED = 180,
   parameter int STEP      = 5,
   parameter int ACC_STEP  = 2,
   parameter int BIG_ERR   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       engine_on,
   input  logic       tick_speed,
   input  logic [3:0] current_gear,
   input  logic [7:0] speed,
   input  logic [7:0] driver_accel,
   input  logic       is_brake_normal,
   input  logic       is_brake_hard,
   input  logic       btn_main,
   input  logic       btn_set,
   input  logic       btn_resume,
   input  logic       btn_cancel,
   output logic [7:0] accel_out,
   output logic [7:0] set_speed,
   output logic       set_valid,
   output logic       cruise_active,
   output logic [1:0] cc_state
);

   typedef enum logic [1:0] {
      S_OFF      = 2'd0,
      S_STANDBY  = 2'd1,
      S_ACTIVE   = 2'd2,
      S_OVERRIDE = 2'd3
   } state_t;

   localparam logic [7:0] MIN_S    = 8'(MIN_SPEED);
   localparam logic [7:0] MAX_S    = 8'(MAX_SPEED);
   localparam logic [7:0] STEP_V   = 8'(STEP);
   localparam logic [7:0] ADJ_SML  = 8'(ACC_STEP);
   localparam logic [7:0] ADJ_BIG  = 8'(2 * ACC_STEP);
   localparam logic [8:0] BIG_ERR_V = 9'(BIG_ERR);

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? 8'h00 : (a - b);
   endfunction

   state_t     state_q, state_d;
   logic [7:0] set_speed_q, set_speed_d;
   logic       set_valid_q, set_valid_d;
   logic [7:0] cruise_q, cruise_d;
   logic [7:0] accel_q, accel_d;
   logic       main_q, set_q, resume_q, cancel_q;
   logic       armed_q;

   logic              main_p, set_p, resume_p, cancel_p;
   logic              brk, ok_gear, engaged;
   logic signed [8:0] err;
   logic [8:0]        err_mag;
   logic [7:0]        adj;

   // The armed flag masks presses for the first cycle after reset so a button
   // held through reset is seen as already-high rather than as a fresh press.
   assign main_p   = armed_q & btn_main   & ~main_q;
   assign set_p    = armed_q & btn_set    & ~set_q;
   assign resume_p = armed_q & btn_resume & ~resume_q;
   assign cancel_p = armed_q & btn_cancel & ~cancel_q;

   assign brk     = is_brake_normal | is_brake_hard;
   assign ok_gear = (current_gear == 4'd12);
   assign engaged = (state_q == S_ACTIVE) || (state_q == S_OVERRIDE);

   assign err     = $signed({1'b0, set_speed_q}) - $signed({1'b0, speed});
   assign err_mag = err[8] ? 9'(-err) : 9'(err);
   assign adj     = (err_mag > BIG_ERR_V) ? ADJ_BIG : ADJ_SML;

   always_comb begin
      state_d     = state_q;
      set_speed_d = set_speed_q;
      set_valid_d = set_valid_q;
      cruise_d    = cruise_q;
      if (!engine_on) begin
         state_d     = S_OFF;
         set_valid_d = 1'b0;
         set_speed_d = '0;
      end else if (main_p) begin
         if (state_q == S_OFF) begin
            state_d = S_STANDBY;
         end else begin
            state_d     = S_OFF;
            set_valid_d = 1'b0;
         end
      end else if (engaged && (brk || cancel_p || !ok_gear || speed < MIN_S)) begin
         state_d = S_STANDBY;
      end else begin
         case (state_q)
            S_STANDBY: begin
               if (set_p && ok_gear && speed >= MIN_S && speed <= MAX_S && !brk) begin
                  state_d     = S_ACTIVE;
                  set_speed_d = speed;
                  set_valid_d = 1'b1;
                  cruise_d    = driver_accel;
               end else if (resume_p && set_valid_q && ok_gear && speed >= MIN_S && !brk) begin
                  state_d  = S_ACTIVE;
                  cruise_d = driver_accel;
               end
            end
            S_ACTIVE: begin
               if (set_p && !resume_p) begin
                  set_speed_d = ({1'b0, set_speed_q} < 9'(MIN_SPEED + STEP)) ?
                                MIN_S : (set_speed_q - STEP_V);
               end else if (resume_p && !set_p) begin
                  set_speed_d = ({1'b0, set_speed_q} + 9'(STEP) > 9'(MAX_SPEED)) ?
                                MAX_S : (set_speed_q + STEP_V);
               end
               // The tick update only applies when the state is not changing.
               if (driver_accel > cruise_q) begin
                  state_d = S_OVERRIDE;
               end else if (tick_speed) begin
                  if (err > 9'sd0)      cruise_d = sat_add(cruise_q, adj);
                  else if (err < 9'sd0) cruise_d = sat_sub(cruise_q, adj);
               end
            end
            S_OVERRIDE: begin
               if (driver_accel <= cruise_q) state_d = S_ACTIVE;
            end
            default: ;
         endcase
      end
      accel_d = brk ? 8'h00 : ((state_d == S_ACTIVE) ? cruise_d : driver_accel);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_OFF;
         set_speed_q <= '0;
         set_valid_q <= 1'b0;
         cruise_q    <= '0;
         accel_q     <= '0;
         main_q      <= 1'b0;
         set_q       <= 1'b0;
         resume_q    <= 1'b0;
         cancel_q    <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         set_speed_q <= set_speed_d;
         set_valid_q <= set_valid_d;
         cruise_q    <= cruise_d;
         accel_q     <= accel_d;
         main_q      <= btn_main;
         set_q       <= btn_set;
         resume_q    <= btn_resume;
         cancel_q    <= btn_cancel;
         armed_q     <= 1'b1;
      end
   end

   assign accel_out     = accel_q;
   assign set_speed     = set_speed_q;
   assign set_valid     = set_valid_q;
   assign cruise_active = (state_q == S_ACTIVE) || (state_q == S_OVERRIDE);
   assign cc_state      = state_q;

endmodule
